video_oam_dma: RTL

- Sprite DMA engine driven by a CPU write to $4014.
- Halts the CPU and copies a 256-byte CPU page into sprite memory using 256 writes to the PPU OAMDATA register (register index 4) on the video block's host register port.
- Sits upstream of the video block, muxed onto its host address/data/write lines while active.
- All timing is in CPU cycles, signalled by a one-clock strobe.

---
 rtl/video_oam_dma.sv | 129 ++++++++++++
 1 files changed

// File: rtl/video_oam_dma.sv
// Sprite DMA engine: on a $4014 write, halts the CPU and streams one 256-byte
// CPU page into OAM through the video block's OAMDATA host register.
module video_oam_dma #(
    parameter logic [2:0]  P_oam_reg = 3'd4,
    parameter int unsigned P_length  = 256,
    parameter bit          P_align   = 1'b1
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_cpu_tick,
    input  logic        I_reg_wren,
    input  logic [7:0]  I_reg_data,
    output logic        O_halt,
    output logic        O_busy,
    output logic [15:0] O_mem_addr,
    output logic        O_mem_rden,
    input  logic [7:0]  I_mem_data,
    output logic [2:0]  O_ppu_addr,
    output logic        O_ppu_wren,
    output logic [7:0]  O_ppu_data
);

    localparam logic [7:0] L_last_index = 8'(P_length - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q, parity_d;

    logic        halt_q, halt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_rden_q, mem_rden_d;
    logic [2:0]  ppu_addr_q, ppu_addr_d;
    logic        ppu_wren_q, ppu_wren_d;
    logic [7:0]  ppu_data_q, ppu_data_d;

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        data_d   = data_q;
        parity_d = parity_q;
        if (I_cpu_tick) begin
            parity_d = ~parity_q;
            case (state_q)
                S_IDLE: begin
                    if (I_reg_wren) begin
                        page_d  = I_reg_data;
                        index_d = 8'h00;
                        state_d = S_HALT;
                    end
                end
                // Post-toggle parity 1 means the next cycle is odd: burn one
                // cycle so the first read lands on an even CPU cycle.
                S_HALT:  state_d = (P_align && parity_d) ? S_ALIGN : S_READ;
                S_ALIGN: state_d = S_READ;
                S_READ: begin
                    data_d  = I_mem_data;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (index_q == L_last_index) begin
                        state_d = S_IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = S_READ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        halt_d     = (state_d != S_IDLE);
        mem_rden_d = (state_d == S_READ);
        mem_addr_d = mem_rden_d ? {page_d, index_d} : 16'h0000;
        ppu_wren_d = (state_d == S_WRITE);
        ppu_addr_d = ppu_wren_d ? P_oam_reg : 3'd0;
        ppu_data_d = ppu_wren_d ? data_d : 8'h00;
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q    <= S_IDLE;
            page_q     <= 8'h00;
            index_q    <= 8'h00;
            data_q     <= 8'h00;
            parity_q   <= 1'b0;
            halt_q     <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_rden_q <= 1'b0;
            ppu_addr_q <= 3'd0;
            ppu_wren_q <= 1'b0;
            ppu_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            index_q    <= index_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            halt_q     <= halt_d;
            mem_addr_q <= mem_addr_d;
            mem_rden_q <= mem_rden_d;
            ppu_addr_q <= ppu_addr_d;
            ppu_wren_q <= ppu_wren_d;
            ppu_data_q <= ppu_data_d;
        end
    end

    assign O_halt     = halt_q;
    assign O_busy     = halt_q;
    assign O_mem_addr = mem_addr_q;
    assign O_mem_rden = mem_rden_q;
    assign O_ppu_addr = ppu_addr_q;
    assign O_ppu_wren = ppu_wren_q;
    assign O_ppu_data = ppu_data_q;

endmodule
